conv_2d_ctrl: RTL and testbench
===============================

Name: conv_2d_ctrl

Overview:
Sequencer for the 3x3 convolution datapath (conv_2d). Accepts kernel coefficients and image columns over valid/ready streams and drives the datapath's i_load_knl, i_en_conv and i_data1..3. Owns the datapath's kernel-load beat count, per-band column windowing and end-of-band flush. Emits a valid strobe aligned with the datapath's o_pixel, plus band/frame completion.

Parameters:
NB_DATA, 8, width of pixel/coefficient lanes
IMG_W, 64, columns per 3-row band (>=3)
N_BANDS, 62, bands per frame (>=1)
NB_CNT, 16, width of column/band counters

Ports:
clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_load_req  in  1  pulse: start kernel load (IDLE only)
i_start  in  1  pulse: start frame (IDLE only)
i_knl_valid  in  1  kernel beat valid
i_knl0..i_knl2  in  NB_DATA each  kernel column beat (rows 1..3)
o_knl_ready  out  1  kernel beat accepted when high with valid
i_col_valid  in  1  image column valid
i_col0..i_col2  in  NB_DATA each  image column (rows 1..3)
o_col_ready  out  1  column accepted when high with valid
o_load_knl  out  1  to datapath i_load_knl
o_en_conv  out  1  to datapath i_en_conv
o_data1..o_data3  out  NB_DATA each  to datapath i_data1..3
o_pix_valid  out  1  datapath o_pixel valid this cycle
o_band_done  out  1  one-cycle pulse, band flushed
o_done  out  1  one-cycle pulse, frame complete
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_nrst=0): state IDLE; all outputs and counters 0.
- States: IDLE, KLOAD, KWRAP, STREAM, FLUSH, DONE.
- IDLE: i_load_req -> KLOAD; else i_start -> STREAM (col_cnt=0, band_cnt=0). Both same cycle: load wins, start dropped. Requests outside IDLE ignored.
- KLOAD: o_knl_ready=1. Each accepted beat is registered: next cycle o_load_knl=1, o_data1..3=i_knl0..2. After the 3rd accepted beat -> KWRAP.
- KWRAP: one extra registered o_load_knl=1 with data 0 (returns the datapath's load counter to 0) -> IDLE. Load sequence therefore = 4 consecutive o_load_knl cycles when beats are back-to-back.
- STREAM: o_col_ready=1. Accepted column -> next cycle o_en_conv=1, o_data=column; otherwise o_en_conv=0 (datapath holds its window). Issue index j = col_cnt at accept. Accept at col_cnt==IMG_W-1 -> FLUSH.
- FLUSH: o_col_ready=0; one issued o_en_conv cycle with data 0, index j=IMG_W; o_band_done pulses the cycle that flush enable is driven. Then band_cnt==N_BANDS-1 -> DONE, else band_cnt++, col_cnt=0 -> STREAM.
- DONE: o_done=1 for one cycle -> IDLE.
- Valid alignment: o_pix_valid registered = (o_en_conv && j>=3), i.e. high the cycle after an enable issued with index 3..IMG_W. Column accept -> o_pix_valid latency 2 cycles. IMG_W-2 valid pixels per band.
- o_pixel is cleared by the datapath whenever enable drops; no output backpressure, consumer samples on o_pix_valid.
- Reset mid-operation: immediate return to IDLE; the datapath kernel is indeterminate, and a kernel load is required before the next frame.

Optional Feature:
CONV_CTRL_STATS_EN: adds output o_stall_cnt[15:0], which counts STREAM cycles with o_col_ready=1 and i_col_valid=0. It saturates at 0xFFFF, clears on i_start acceptance, and resets to 0. Without the macro, the port and counter are absent.

Test Plan:
- Kernel beats (1,2,3),(4,5,6),(7,8,9) back-to-back -> o_load_knl high 4 cycles starting 1 cycle after first accept, data 1,2,3 / 4,5,6 / 7,8,9 / 0,0,0; o_busy low afterwards.
- IMG_W=4, N_BANDS=2, all-ones kernel, columns (1,1,1),(2,2,2),(3,3,3),(4,4,4) per band -> 5 enables/band, o_pixel 18 then 27 on o_pix_valid each band, 2 o_band_done, 1 o_done.
- Same as above with i_col_valid low every other cycle -> enables gapped, o_pix_valid results still 18, 27 per band.
- i_load_req and i_start same cycle in IDLE -> load runs, start ignored; i_start during STREAM -> no effect.
- Assert i_nrst=0 mid-band -> all outputs 0 same cycle, state IDLE; reload + restart reproduces 18, 27.
- With CONV_CTRL_STATS_EN, 3 idle STREAM cycles -> o_stall_cnt=3, cleared on next i_start.

Source files
------------

// File: rtl/conv_2d_ctrl_if.sv
// Stream and datapath-drive bundle for conv_2d_ctrl. The slave modport is the controller side.
// o_stall_cnt exists only when CONV_CTRL_STATS_EN is defined.
interface conv_2d_ctrl_if #(
  parameter int NB_DATA = 8
);
  logic               i_load_req;
  logic               i_start;
  logic               i_knl_valid;
  logic [NB_DATA-1:0] i_knl0;
  logic [NB_DATA-1:0] i_knl1;
  logic [NB_DATA-1:0] i_knl2;
  logic               o_knl_ready;
  logic               i_col_valid;
  logic [NB_DATA-1:0] i_col0;
  logic [NB_DATA-1:0] i_col1;
  logic [NB_DATA-1:0] i_col2;
  logic               o_col_ready;
  logic               o_load_knl;
  logic               o_en_conv;
  logic [NB_DATA-1:0] o_data1;
  logic [NB_DATA-1:0] o_data2;
  logic [NB_DATA-1:0] o_data3;
  logic               o_pix_valid;
  logic               o_band_done;
  logic               o_done;
  logic               o_busy;
`ifdef CONV_CTRL_STATS_EN
  logic [15:0]        o_stall_cnt;
`endif

  modport slave (
    input  i_load_req, i_start, i_knl_valid, i_knl0, i_knl1, i_knl2,
    input  i_col_valid, i_col0, i_col1, i_col2,
    output o_knl_ready, o_col_ready, o_load_knl, o_en_conv,
    output o_data1, o_data2, o_data3, o_pix_valid, o_band_done, o_done, o_busy
`ifdef CONV_CTRL_STATS_EN
    , output o_stall_cnt
`endif
  );

  modport master (
    output i_load_req, i_start, i_knl_valid, i_knl0, i_knl1, i_knl2,
    output i_col_valid, i_col0, i_col1, i_col2,
    input  o_knl_ready, o_col_ready, o_load_knl, o_en_conv,
    input  o_data1, o_data2, o_data3, o_pix_valid, o_band_done, o_done, o_busy
`ifdef CONV_CTRL_STATS_EN
    , input o_stall_cnt
`endif
  );
endinterface

// File: rtl/conv_2d_ctrl.sv
// Sequencer for the 3x3 conv_2d datapath: accepted beat -> registered drive next cycle, pixel valid 2 cycles after accept;
// ready is a pure function of state, outputs have no backpressure. CONV_CTRL_STATS_EN adds a saturating stall counter.
module conv_2d_ctrl #(
  parameter int NB_DATA = 8,
  parameter int IMG_W   = 64,
  parameter int N_BANDS = 62,
  parameter int NB_CNT  = 16
) (
  input logic           clk,
  input logic           i_nrst,
  conv_2d_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KLOAD, KWRAP, STREAM, FLUSH, DONE} state_t;

  localparam logic [NB_CNT-1:0] LAST_COL  = NB_CNT'(IMG_W - 1);
  localparam logic [NB_CNT-1:0] LAST_BAND = NB_CNT'(N_BANDS - 1);
  localparam logic [NB_CNT-1:0] FIRST_PIX = NB_CNT'(3);
  localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);

  state_t             state_q, state_d;
  logic [1:0]         knl_cnt_q, knl_cnt_d;
  logic [NB_CNT-1:0]  col_cnt_q, col_cnt_d;
  logic [NB_CNT-1:0]  band_cnt_q, band_cnt_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic               pix_pend_q, pix_pend_d;
  logic               pix_vld_q, pix_vld_d;
  logic               band_done_q, band_done_d;
  logic               done_q, done_d;
  logic [NB_DATA-1:0] data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;
  logic               knl_acc, col_acc;

  assign knl_acc = (state_q == KLOAD) && bus.i_knl_valid;
  assign col_acc = (state_q == STREAM) && bus.i_col_valid;

  always_comb begin
    state_d     = state_q;
    knl_cnt_d   = knl_cnt_q;
    col_cnt_d   = col_cnt_q;
    band_cnt_d  = band_cnt_q;
    load_d      = 1'b0;
    en_d        = 1'b0;
    pix_pend_d  = 1'b0;
    pix_vld_d   = pix_pend_q;
    band_done_d = 1'b0;
    done_d      = 1'b0;
    data1_d     = '0;
    data2_d     = '0;
    data3_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.i_load_req) begin
          state_d   = KLOAD;
          knl_cnt_d = 2'd0;
        end else if (bus.i_start) begin
          state_d    = STREAM;
          col_cnt_d  = '0;
          band_cnt_d = '0;
        end
      end
      KLOAD: begin
        if (knl_acc) begin
          load_d    = 1'b1;
          data1_d   = bus.i_knl0;
          data2_d   = bus.i_knl1;
          data3_d   = bus.i_knl2;
          knl_cnt_d = knl_cnt_q + 2'd1;
          if (knl_cnt_q == 2'd2) state_d = KWRAP;
        end
      end
      // Fourth zero beat walks the datapath's load counter back to zero.
      KWRAP: begin
        load_d  = 1'b1;
        state_d = IDLE;
      end
      STREAM: begin
        if (col_acc) begin
          en_d       = 1'b1;
          data1_d    = bus.i_col0;
          data2_d    = bus.i_col1;
          data3_d    = bus.i_col2;
          pix_pend_d = (col_cnt_q >= FIRST_PIX);
          col_cnt_d  = col_cnt_q + CNT_ONE;
          if (col_cnt_q == LAST_COL) state_d = FLUSH;
        end
      end
      // Zero column pushes the last window through; its index is IMG_W, so it always yields a pixel.
      FLUSH: begin
        en_d        = 1'b1;
        pix_pend_d  = 1'b1;
        band_done_d = 1'b1;
        if (band_cnt_q == LAST_BAND) begin
          state_d = DONE;
        end else begin
          band_cnt_d = band_cnt_q + CNT_ONE;
          col_cnt_d  = '0;
          state_d    = STREAM;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= IDLE;
      knl_cnt_q   <= '0;
      col_cnt_q   <= '0;
      band_cnt_q  <= '0;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      pix_pend_q  <= 1'b0;
      pix_vld_q   <= 1'b0;
      band_done_q <= 1'b0;
      done_q      <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      data3_q     <= '0;
    end else begin
      state_q     <= state_d;
      knl_cnt_q   <= knl_cnt_d;
      col_cnt_q   <= col_cnt_d;
      band_cnt_q  <= band_cnt_d;
      load_q      <= load_d;
      en_q        <= en_d;
      pix_pend_q  <= pix_pend_d;
      pix_vld_q   <= pix_vld_d;
      band_done_q <= band_done_d;
      done_q      <= done_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      data3_q     <= data3_d;
    end
  end

  assign bus.o_knl_ready = (state_q == KLOAD);
  assign bus.o_col_ready = (state_q == STREAM);
  assign bus.o_load_knl  = load_q;
  assign bus.o_en_conv   = en_q;
  assign bus.o_data1     = data1_q;
  assign bus.o_data2     = data2_q;
  assign bus.o_data3     = data3_q;
  assign bus.o_pix_valid = pix_vld_q;
  assign bus.o_band_done = band_done_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = (state_q != IDLE);

`ifdef CONV_CTRL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && bus.i_start && !bus.i_load_req) begin
      stall_cnt_d = '0;
    end else if ((state_q == STREAM) && !bus.i_col_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_conv_2d_ctrl.sv
// Bench for conv_2d_ctrl with a behavioural 3x3 datapath and a per-band pixel reference.
module tb_conv_2d_ctrl;
  localparam int NB_DATA = 8;
  localparam int IMG_W   = 4;
  localparam int N_BANDS = 2;
  localparam int NB_CNT  = 16;
  localparam int N_COLS  = IMG_W * N_BANDS;
  localparam int GUARD   = 2000;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  conv_2d_ctrl_if #(.NB_DATA(NB_DATA)) bus ();

  conv_2d_ctrl #(.NB_DATA(NB_DATA), .IMG_W(IMG_W), .N_BANDS(N_BANDS), .NB_CNT(NB_CNT)) u_dut (
    .clk(clk), .i_nrst(nrst), .bus(bus)
  );

  // Behavioural datapath: first three load beats are kernel columns, window shifts on enable,
  // and the pixel of the window held before the shift appears the next cycle.
  logic [7:0] kmem [0:2][0:2];
  logic [7:0] win  [0:2][0:2];
  logic [1:0] lcnt;
  int         pixel;
  int         dp_acc;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lcnt  <= 2'd0;
      pixel <= 0;
    end else begin
      if (bus.o_load_knl) begin
        if (lcnt < 2'd3) begin
          kmem[lcnt][0] <= bus.o_data1;
          kmem[lcnt][1] <= bus.o_data2;
          kmem[lcnt][2] <= bus.o_data3;
        end
        lcnt <= lcnt + 2'd1;
      end
      if (bus.o_en_conv) begin
        dp_acc = 0;
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            dp_acc += int'(kmem[c][r]) * int'(win[c][r]);
        pixel <= dp_acc;
        for (int r = 0; r < 3; r++) begin
          win[0][r] <= win[1][r];
          win[1][r] <= win[2][r];
        end
        win[2][0] <= bus.o_data1;
        win[2][1] <= bus.o_data2;
        win[2][2] <= bus.o_data3;
      end else begin
        pixel <= 0;
      end
    end
  end

  int n_tests, n_fail;
  int cyc, n_en, n_bd, n_done, first_pv;
  int pixq[$];
  logic [7:0] kern [0:2][0:2];
  logic [7:0] colv [0:N_COLS-1][0:2];

  typedef struct {
    logic       load_req, start, kv;
    logic [7:0] k0, k1, k2;
    logic       e_kr, e_cr, e_load, e_busy;
    logic [7:0] e_d1, e_d2, e_d3;
  } vec_t;
  vec_t vt [12];

  function automatic vec_t mk(logic lr, logic st, logic kv, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                              logic kr, logic cr, logic ld, logic by,
                              logic [7:0] x, logic [7:0] y, logic [7:0] z);
    vec_t v;
    v.load_req = lr; v.start = st; v.kv = kv; v.k0 = a; v.k1 = b; v.k2 = c;
    v.e_kr = kr; v.e_cr = cr; v.e_load = ld; v.e_busy = by;
    v.e_d1 = x; v.e_d2 = y; v.e_d3 = z;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_all();
    return {bus.o_knl_ready, bus.o_col_ready, bus.o_load_knl, bus.o_en_conv, bus.o_pix_valid,
            bus.o_band_done, bus.o_done, bus.o_busy, bus.o_data1, bus.o_data2, bus.o_data3};
  endfunction

  // Pixel p of band b: kernel column c weights image column p+c of that band.
  function automatic int ref_pixel(int b, int p);
    int s;
    s = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        s += int'(kern[c][r]) * int'(colv[b*IMG_W + p + c][r]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.o_en_conv)   n_en++;
    if (bus.o_band_done) n_bd++;
    if (bus.o_done)      n_done++;
    if (bus.o_pix_valid) begin
      pixq.push_back(pixel);
      if (first_pv < 0) first_pv = cyc;
    end
  endtask

  task automatic clear_inputs();
    bus.i_load_req = 0; bus.i_start = 0; bus.i_knl_valid = 0;
    bus.i_knl0 = 0; bus.i_knl1 = 0; bus.i_knl2 = 0;
    bus.i_col_valid = 0; bus.i_col0 = 0; bus.i_col1 = 0; bus.i_col2 = 0;
  endtask

  task automatic load_kernel();
    int guard;
    bus.i_load_req = 1; tick(); bus.i_load_req = 0;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("kl_ready%0d", b), bus.o_knl_ready, 1);
      bus.i_knl_valid = 1;
      bus.i_knl0 = kern[b][0]; bus.i_knl1 = kern[b][1]; bus.i_knl2 = kern[b][2];
      tick();
    end
    bus.i_knl_valid = 0;
    guard = 0;
    while (bus.o_busy && guard < 20) begin tick(); guard++; end
    check("kl_bound", guard < 20, 1);
  endtask

  // gap: 0 back-to-back, 1 valid every other cycle, 2 random, 3 three idle cycles then back-to-back.
  task automatic run_frame(input int gap, input bit poke, input string tag);
    int  idx, guard, j3_cyc, k;
    bit  v, acc;
    n_en = 0; n_bd = 0; n_done = 0; first_pv = -1; pixq.delete();
    bus.i_start = 1; tick(); bus.i_start = 0;
    idx = 0; guard = 0; j3_cyc = -1;
    while (idx < N_COLS && guard < GUARD) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        3:       v = guard >= 3;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.i_start     = poke && (guard == 2);
      bus.i_col_valid = v;
      bus.i_col0 = colv[idx][0]; bus.i_col1 = colv[idx][1]; bus.i_col2 = colv[idx][2];
      acc = v && bus.o_col_ready;
      if (acc && idx == 3) j3_cyc = cyc;
      tick();
      if (acc) idx++;
      guard++;
    end
    bus.i_col_valid = 0; bus.i_start = 0;
    check({tag, "_feed_bound"}, guard < GUARD, 1);
    guard = 0;
    while (n_done == 0 && guard < 50) begin tick(); guard++; end
    check({tag, "_done_bound"}, guard < 50, 1);
    repeat (2) tick();
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_band_done_cnt"}, n_bd, N_BANDS);
    check({tag, "_en_cnt"}, n_en, N_BANDS * (IMG_W + 1));
    check({tag, "_busy_after"}, bus.o_busy, 0);
    check({tag, "_pix_cnt"}, pixq.size(), N_BANDS * (IMG_W - 2));
    check({tag, "_pv_latency"}, first_pv - j3_cyc, 2);
    k = 0;
    for (int b = 0; b < N_BANDS; b++)
      for (int p = 0; p < IMG_W - 2; p++) begin
        if (k < pixq.size()) check($sformatf("%s_pix_b%0d_p%0d", tag, b, p), pixq[k], ref_pixel(b, p));
        k++;
      end
  endtask

  task automatic ramp_columns();
    for (int b = 0; b < N_BANDS; b++)
      for (int i = 0; i < IMG_W; i++)
        for (int r = 0; r < 3; r++) colv[b*IMG_W + i][r] = 8'(i + 1);
  endtask

  task automatic ones_kernel();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) kern[c][r] = 8'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; n_en = 0; n_bd = 0; n_done = 0; first_pv = -1;
    clear_inputs();
    nrst = 1;
    #2 nrst = 0;
    #1 check("reset_outs", outs_all(), 0);
    @(negedge clk) nrst = 1;
    tick();
    check("idle_outs", outs_all(), 0);

    vt[0]  = mk(1,0,0, 0,0,0, 1,0,0,1, 0,0,0);
    vt[1]  = mk(0,0,1, 1,2,3, 1,0,1,1, 1,2,3);
    vt[2]  = mk(0,0,1, 4,5,6, 1,0,1,1, 4,5,6);
    vt[3]  = mk(0,0,1, 7,8,9, 0,0,1,1, 7,8,9);
    vt[4]  = mk(0,0,0, 0,0,0, 0,0,1,0, 0,0,0);
    vt[5]  = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0);
    vt[6]  = mk(1,1,0, 0,0,0, 1,0,0,1, 0,0,0);
    vt[7]  = mk(0,1,1, 1,1,1, 1,0,1,1, 1,1,1);
    vt[8]  = mk(0,0,1, 1,1,1, 1,0,1,1, 1,1,1);
    vt[9]  = mk(0,0,1, 1,1,1, 0,0,1,1, 1,1,1);
    vt[10] = mk(0,0,0, 0,0,0, 0,0,1,0, 0,0,0);
    vt[11] = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0);
    for (int i = 0; i < 12; i++) begin
      bus.i_load_req = vt[i].load_req; bus.i_start = vt[i].start; bus.i_knl_valid = vt[i].kv;
      bus.i_knl0 = vt[i].k0; bus.i_knl1 = vt[i].k1; bus.i_knl2 = vt[i].k2;
      tick();
      check($sformatf("tbl%0d_knl_ready", i), bus.o_knl_ready, vt[i].e_kr);
      check($sformatf("tbl%0d_col_ready", i), bus.o_col_ready, vt[i].e_cr);
      check($sformatf("tbl%0d_load_knl", i), bus.o_load_knl, vt[i].e_load);
      check($sformatf("tbl%0d_busy", i), bus.o_busy, vt[i].e_busy);
      check($sformatf("tbl%0d_data", i), {bus.o_data1, bus.o_data2, bus.o_data3},
            {vt[i].e_d1, vt[i].e_d2, vt[i].e_d3});
    end
    clear_inputs();

    ones_kernel();
    ramp_columns();
    run_frame(0, 1'b1, "b2b");
    run_frame(1, 1'b0, "gapped");

    bus.i_start = 1; tick(); bus.i_start = 0;
    bus.i_col_valid = 1;
    bus.i_col0 = 8'd1; bus.i_col1 = 8'd1; bus.i_col2 = 8'd1;
    repeat (3) tick();
    check("midband_en_before_rst", bus.o_en_conv, 1);
    #2 nrst = 0;
    #1 check("midband_rst_outs", outs_all(), 0);
    clear_inputs();
    @(negedge clk) nrst = 1;
    tick();
    check("post_rst_outs", outs_all(), 0);
    load_kernel();
    run_frame(0, 1'b0, "after_rst");

`ifdef CONV_CTRL_STATS_EN
    run_frame(3, 1'b0, "stats");
    check("stall_cnt_3", bus.o_stall_cnt, 3);
    bus.i_start = 1; tick(); bus.i_start = 0;
    check("stall_cnt_clear", bus.o_stall_cnt, 0);
    #2 nrst = 0;
    #1 check("stats_rst_outs", outs_all(), 0);
    @(negedge clk) nrst = 1;
    tick();
`endif

    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) kern[c][r] = 8'($urandom_range(0, 15));
      for (int i = 0; i < N_COLS; i++)
        for (int r = 0; r < 3; r++) colv[i][r] = 8'($urandom_range(0, 31));
      load_kernel();
      run_frame(2, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
